// File: rtl/direction_arbiter_if.sv
// Request/select bundle between the four direction requesters and the arbiter
// that drives the shared direction multiplexer.
interface direction_arbiter_if;
   logic       up;
   logic       right;
   logic       down;
   logic       left;
   logic       select1;
   logic       select0;
   logic [3:0] grant;
   logic       busy;
   logic       done;

   modport master (
      output up, right, down, left,
      input  select1, select0, grant, busy, done
   );

   modport slave (
      input  up, right, down, left,
      output select1, select0, grant, busy, done
   );
endinterface

// File: rtl/direction_arbiter.sv
// Round-robin, non-preemptive arbiter for the four-way direction mux: one
// direction is granted for HOLD_CYCLES cycles, and back-to-back windows have no gap.
module direction_arbiter #(
   parameter int HOLD_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   direction_arbiter_if.slave  bus
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam logic [7:0] RELOAD   = 8'(HOLD_CYCLES - 1);
   localparam logic       HOLD_ONE = (HOLD_CYCLES == 1);

   state_t     state_r;
   logic [1:0] ptr_r;
   logic [7:0] count_r;
   logic [1:0] sel_r;
   logic [3:0] grant_r;
   logic       busy_r;
   logic       done_r;

   logic [3:0] req_s;
   logic [1:0] base_s;
   logic [2:0] pick_s;

   // First asserted request at or after base, wrapping; returns {found, index}.
   function automatic logic [2:0] pick(input logic [3:0] req, input logic [1:0] base);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         idx = base + 2'(i);
         if (req[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   assign req_s = {bus.left, bus.down, bus.right, bus.up};

   // At expiry the search already starts past the direction just served.
   always_comb begin
      base_s = ptr_r;
      if (state_r == HOLD) begin
         base_s = sel_r + 2'd1;
      end else begin
         base_s = ptr_r;
      end
      pick_s = pick(req_s, base_s);
   end

   // Arbitration state machine with registered mux select and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         ptr_r   <= 2'b00;
         count_r <= 8'd0;
         sel_r   <= 2'b00;
         grant_r <= 4'b0000;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (pick_s[2]) begin
                  state_r <= HOLD;
                  sel_r   <= pick_s[1:0];
                  grant_r <= 4'b0001 << pick_s[1:0];
                  busy_r  <= 1'b1;
                  count_r <= RELOAD;
                  done_r  <= HOLD_ONE;
               end else begin
                  grant_r <= 4'b0000;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b0;
               end
            end
            HOLD: begin
               if (count_r != 8'd0) begin
                  count_r <= count_r - 8'd1;
                  done_r  <= (count_r == 8'd1);
               end else begin
                  ptr_r <= sel_r + 2'd1;
                  if (pick_s[2]) begin
                     sel_r   <= pick_s[1:0];
                     grant_r <= 4'b0001 << pick_s[1:0];
                     busy_r  <= 1'b1;
                     count_r <= RELOAD;
                     done_r  <= HOLD_ONE;
                  end else begin
                     state_r <= IDLE;
                     grant_r <= 4'b0000;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b0;
                  end
               end
            end
            default: begin
               state_r <= IDLE;
               grant_r <= 4'b0000;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               count_r <= 8'd0;
            end
         endcase
      end
   end

   assign bus.select1 = sel_r[1];
   assign bus.select0 = sel_r[0];
   assign bus.grant   = grant_r;
   assign bus.busy    = busy_r;
   assign bus.done    = done_r;

endmodule

// File: tb/tb_direction_arbiter.sv
// Bench for direction_arbiter: one instance with 4-cycle windows and one with
// single-cycle windows, both checked against a window-level reference model.
module tb_direction_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] req_v;

   int n_checks;
   int n_pass;

   direction_arbiter_if b4 ();
   direction_arbiter_if b1 ();

   assign b4.up = req_v[0];
   assign b4.right = req_v[1];
   assign b4.down = req_v[2];
   assign b4.left = req_v[3];
   assign b1.up = req_v[0];
   assign b1.right = req_v[1];
   assign b1.down = req_v[2];
   assign b1.left = req_v[3];

   direction_arbiter #(.HOLD_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
   direction_arbiter #(.HOLD_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: index 0 models HOLD_CYCLES=4, index 1 models HOLD_CYCLES=1.
   int m_hold [2] = '{4, 1};
   bit m_active [2];
   int m_g [2];
   int m_left [2];
   int m_ptr [2];
   int m_sel [2];

   typedef struct {
      logic [3:0] req;
      logic [3:0] grant;
      logic [1:0] sel;
      logic       busy;
      logic       done;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_active[k] = 1'b0;
         m_g[k] = 0;
         m_left[k] = 0;
         m_ptr[k] = 0;
         m_sel[k] = 0;
      end
   endtask

   task automatic model_step(input logic [3:0] req);
      bit found;
      int d;
      for (int k = 0; k < 2; k++) begin
         if (m_active[k] && m_left[k] > 1) begin
            m_left[k]--;
         end else begin
            if (m_active[k]) m_ptr[k] = (m_g[k] + 1) % 4;
            found = 1'b0;
            for (int i = 0; i < 4; i++) begin
               d = (m_ptr[k] + i) % 4;
               if (!found && req[d]) begin
                  found = 1'b1;
                  m_g[k] = d;
                  m_sel[k] = d;
                  m_left[k] = m_hold[k];
               end
            end
            m_active[k] = found;
         end
      end
   endtask

   task automatic check_models();
      int eg;
      for (int k = 0; k < 2; k++) begin
         eg = m_active[k] ? (1 << m_g[k]) : 0;
         if (k == 0) begin
            check("m4.grant", int'(b4.grant), eg);
            check("m4.sel", int'({b4.select1, b4.select0}), m_sel[k]);
            check("m4.busy", int'(b4.busy), int'(m_active[k]));
            check("m4.done", int'(b4.done), int'(m_active[k] && m_left[k] == 1));
         end else begin
            check("m1.grant", int'(b1.grant), eg);
            check("m1.sel", int'({b1.select1, b1.select0}), m_sel[k]);
            check("m1.busy", int'(b1.busy), int'(m_active[k]));
            check("m1.done", int'(b1.done), int'(m_active[k] && m_left[k] == 1));
         end
      end
   endtask

   task automatic step(input logic [3:0] req);
      req_v = req;
      @(posedge clk);
      model_step(req);
      #1;
      check_models();
   endtask

   task automatic do_reset();
      req_v = 4'b0000;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst.grant", int'(b4.grant), 0);
      check("rst.sel", int'({b4.select1, b4.select0}), 0);
      check("rst.busy", int'(b4.busy), 0);
      check("rst.done", int'(b4.done), 0);
      rst_n = 1'b1;
   endtask

   vec_t vecs [14];

   initial begin
      n_checks = 0;
      n_pass = 0;
      req_v = 4'b0000;
      rst_n = 1'b0;

      // HOLD_CYCLES=4 expectations, derived by hand from reset.
      vecs[0]  = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
      vecs[1]  = '{4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
      vecs[2]  = '{4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
      vecs[3]  = '{4'b0000, 4'b0001, 2'd0, 1'b1, 1'b1};
      vecs[4]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
      vecs[5]  = '{4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0};
      vecs[6]  = '{4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0};
      vecs[7]  = '{4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0};
      vecs[8]  = '{4'b1111, 4'b1000, 2'd3, 1'b1, 1'b1};
      vecs[9]  = '{4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0};
      vecs[10] = '{4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
      vecs[11] = '{4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
      vecs[12] = '{4'b0000, 4'b0001, 2'd0, 1'b1, 1'b1};
      vecs[13] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

      do_reset();
      for (int i = 0; i < 14; i++) begin
         step(vecs[i].req);
         check($sformatf("vec%0d.grant", i), int'(b4.grant), int'(vecs[i].grant));
         check($sformatf("vec%0d.sel", i), int'({b4.select1, b4.select0}), int'(vecs[i].sel));
         check($sformatf("vec%0d.busy", i), int'(b4.busy), int'(vecs[i].busy));
         check($sformatf("vec%0d.done", i), int'(b4.done), int'(vecs[i].done));
      end

      // Idle request from down (pointer now at right) grants one cycle later.
      step(4'b0100);
      check("down.grant", int'(b4.grant), 4);
      check("down.sel", int'({b4.select1, b4.select0}), 2);

      // Asynchronous reset mid-window clears outputs before the next edge.
      rst_n = 1'b0;
      #1;
      check("arst.grant", int'(b4.grant), 0);
      check("arst.sel", int'({b4.select1, b4.select0}), 0);
      check("arst.busy", int'(b4.busy), 0);
      check("arst.done", int'(b4.done), 0);
      model_reset();
      req_v = 4'b0000;
      @(negedge clk);
      rst_n = 1'b1;
      step(4'b1010);
      check("post_rst.grant", int'(b4.grant), 2);
      check("post_rst.sel", int'({b4.select1, b4.select0}), 1);

      // Fairness: up+down at the end of a right window -> down, then up.
      step(4'b0000);
      step(4'b0000);
      step(4'b0000);
      check("fair.done", int'(b4.done), 1);
      step(4'b0101);
      check("fair.down", int'(b4.grant), 4);
      for (int i = 0; i < 3; i++) step(4'b0101);
      step(4'b0101);
      check("fair.up", int'(b4.grant), 1);

      // Single-cycle windows rotate every cycle with done held high.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(4'b1111);
         check($sformatf("h1.sel%0d", i), int'({b1.select1, b1.select0}), i % 4);
         check($sformatf("h1.done%0d", i), int'(b1.done), 1);
      end

      // Randomized traffic against the model, including idle stretches.
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(3) == 0) step(4'b0000);
         else step(4'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/direction_arbiter.md
# direction_arbiter

Round-robin arbiter that shares the four-way direction multiplexer between the up, right, down and left requesters. It drives the multiplexer's two select lines and grants one direction at a time for a fixed, parameterized window. It sits directly in front of the mux select inputs, so the mux output always reflects exactly one granted direction.

## Interface

- `HOLD_CYCLES`, default 4: length of each grant window in clock cycles; legal range 1..255.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `up`  in  1  request from the up source; synchronous to `clk`, level-sensitive.
- `right`  in  1  request from the right source; same rules.
- `down`  in  1  request from the down source; same rules.
- `left`  in  1  request from the left source; same rules.
- `select1`  out  1  mux select MSB.
- `select0`  out  1  mux select LSB; `{select1,select0}` is 00 = up, 01 = right, 10 = down, 11 = left.
- `grant`  out  4  one-hot grant, `{left,down,right,up}`; 0000 when idle.
- `busy`  out  1  high while a grant window is active.
- `done`  out  1  high during the final cycle of every grant window.

## Operation

- FSM with two states, IDLE and HOLD. Internal 2-bit priority pointer `ptr` uses the same encoding as select. Internal down-counter is 8 bits wide.
- Search order starts at `ptr` and rotates up → right → down → left → up. The first asserted request found wins.
- **IDLE:**
  - With no requests, the block stays in IDLE. `grant` = 0000 and `busy` = 0.
  - With any request, the next edge loads the winner into select and `grant`, sets `busy`, loads count = `HOLD_CYCLES`−1, and moves to HOLD.
- **HOLD:**
  - While count ≠ 0, count decrements each cycle. `grant` and select stay frozen.
  - The window is non-preemptive. Request changes, including the granted request dropping, are ignored until expiry.
- **Expiry** (HOLD with count = 0):
  - `done` = 1 this cycle. On the edge, `ptr` ← granted index + 1 (mod 4).
  - The requests seen on that edge are arbitrated from the new `ptr`.
  - If any request is present, the winner is granted on that edge with no idle bubble. The state stays HOLD and count reloads to `HOLD_CYCLES`−1.
  - If no request is present, the next state is IDLE, `grant` goes to 0000 and `busy` to 0.
- A sole requester is re-granted back-to-back, because the search wraps around to it.
- Select holds its last granted value while idle, so the mux output stays defined. It changes only when a new grant is issued.
- `done` = (state == HOLD) && (count == 0), decoded from registered state only; it has no combinational path from the request inputs.
- **Reset** (`rst_n` low, any time, including mid-window): outputs clear immediately, asynchronously.
  - state = IDLE, `ptr` = 00, count = 0.
  - `grant` = 0000, `{select1,select0}` = 00, `busy` = 0, `done` = 0.
  - The first arbitration after reset gives up the highest priority.

## Timing

- Request-to-grant latency is 1 cycle: a request sampled at edge N in IDLE shows on `grant`/select after edge N.
- Every grant window lasts exactly `HOLD_CYCLES` cycles. `done` is high in cycle `HOLD_CYCLES` of the window.
- When `HOLD_CYCLES` = 1:
  - count is always 0 and `done` is high in every grant cycle.
  - Under continuous requests the grant rotates every cycle.
- Between consecutive windows there is zero dead cycles when requests are pending, and the block returns to IDLE one cycle after expiry otherwise.
- The block does no synchronization or debouncing; inputs arrive already synchronous to `clk`.

## Test plan

- **Async reset:** assert `rst_n` = 0 mid-window (`grant` = 0100, select 10). Outputs go to `grant` = 0000, select 00, `busy` = 0 and `done` = 0 before the next edge. After release, with `right` and `left` both requesting, right is granted first (select 01).
- **Sole requester, `HOLD_CYCLES` = 4:** hold `up` high. `grant` = 0001 continuously, select 00, `busy` = 1 and `done` high every 4th cycle. Drop `up` at the start of a window: the grant still holds 4 cycles, then `grant` = 0000 and `busy` = 0 the cycle after `done`.
- **All four requesting, `HOLD_CYCLES` = 4:** grants follow 0001, 0010, 0100, 1000, 0001, each exactly 4 cycles. Select follows 00, 01, 10, 11, 00, with no gap cycles.
- **Pointer fairness:** after a right window, present `up` and `down` together at expiry. Down is granted (select 10); up is granted in the following window if it is still requesting.
- **Single-cycle windows (`HOLD_CYCLES` = 1):** with all four requesting, select changes every cycle 00→01→10→11→00 and `done` stays high throughout.
- **Idle behaviour:** after left completes with no further requests, `grant` = 0000 and select stays 11. A later request from `down` gives `grant` = 0100 exactly 1 cycle after it is sampled.
